operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Pipeline stage directly downstream of the decode stage; consumes its registered opcode, function type, operand fields and read/write flags.
- Holds the architectural register file and reads the primary and secondary operands. Selects the immediate for register-immediate forms.
- Keeps a pending-write scoreboard. Stalls on RAW/WAW hazards using a one-entry hold register, and forwards same-cycle writeback data.
- Issues fully resolved operands to the execute stage.

Parameters:
- DATA_W, 16, register and operand width (matches secondary operand width)
- REG_COUNT, 32, number of architectural registers
- REG_ADDR_W, 5, register index width (log2 REG_COUNT)

Ports:
- clock_i  in  1  sole clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- enable_i  in  1  valid instruction from decode
- opcode_i  in  7  opcode from decode
- functionType_i  in  2  0 nop, 1 arith, 2 load/store, 3 flow control
- format_i  in  1  1 = register-immediate, 0 = register-register (carried alongside decode outputs)
- primOperand_i  in  5  primary register index
- secOperand_i  in  16  immediate, or register index in bits [4:0]
- pRead_i, pWrite_i, sRead_i  in  1 each  operand usage flags from decode
- wbEnable_i  in  1  writeback valid
- wbReg_i  in  REG_ADDR_W  writeback register
- wbData_i  in  DATA_W  writeback data
- stall_o  out  1  combinational; high = upstream must hold its current instruction
- enable_o  out  1  valid to execute
- opcode_o  out  7, functionType_o  out  2, destReg_o  out  REG_ADDR_W, pWrite_o  out  1: pass-through fields
- primVal_o  out  DATA_W  primary operand value (0 if pRead clear)
- secVal_o  out  DATA_W  secondary operand value or immediate

Behaviour:
- Reset (async, on reset_i high): all outputs 0; register file all 0; scoreboard all clear; hold register invalid. Reset mid-stall discards the held instruction.
- Candidate instruction each cycle:
  - the hold register if it is valid, else the enable_i inputs.
  - enable_i asserted while stall_o is high is a protocol violation and is ignored.
- Secondary is a register when sRead_i=1 and format_i=0. Otherwise secVal_o is secOperand_i taken verbatim (16-bit immediate, no extension).
- Hazard exists if any of:
  - pRead and pending[prim];
  - secondary is a register and pending[sec[4:0]];
  - pWrite and pending[prim] (WAW).
- A register also being written back this cycle counts as not pending and is forwarded from wbData_i.
- Candidate with no hazard issues at the next edge:
  - enable_o=1, with the read values (forwarded or from the file);
  - if pWrite, set pending[prim];
  - hold register cleared.
- Latency is 1 cycle from decode enable_i to enable_o.
- Candidate with a hazard:
  - captured into (or kept in) the hold register; enable_o=0 next cycle;
  - stall_o high while the hold register is valid;
  - re-evaluated every cycle; issues on the edge at or after the writeback that clears its hazard.
- functionType 0 (nop) with enable: issues with enable_o=1, no reads, no scoreboard change, never stalls.
- Writeback:
  - file[wbReg] <= wbData at the edge;
  - pending[wbReg] cleared, unless an issuing instruction sets the same bit in the same cycle, in which case set wins.
- Bits that are not read drive 0 on primVal_o/secVal_o.
- No enable_i and no hold: enable_o=0; other outputs keep their previous values.

Decomposition:
- Shared package `pa_pkg`:
  - function-type constants FT_NOP/FT_ARITH/FT_LDST/FT_FLOW;
  - DATA_W and REG_ADDR_W defaults;
  - format constants FMT_RR/FMT_RI.
- One natural sub-module, `reg_file_2r1w`: 32x16, two async read ports, one sync write port, async reset.
- Scoreboard, hazard logic and hold register stay in operand_fetch.

Test Plan:
- Write r3=0x1234 via wb; then reg-reg add prim=3, sec=3 -> next cycle enable_o=1, primVal_o=0x1234, secVal_o=0x1234, destReg_o=3.
- Reg-imm add prim=2, imm 0xBEEF -> secVal_o=0xBEEF, pending[2] set. Following add reading r2 -> stall_o=1, enable_o=0. wb r2=0x0005 the cycle after -> issue with primVal_o=0x0005 on that edge.
- Hazard on r4 stalled; wbEnable r4=0x00AA in the same cycle -> no stall cycle (forwarded), primVal_o=0x00AA.
- Issue write to r7 in the same cycle as an old wb to r7 -> pending[7] stays set; next reader of r7 stalls.
- Load (pWrite, prim=1) while pending[1] (WAW) -> stall until wb r1, then issue and pending[1] set again.
- Assert reset_i during a stall -> outputs 0, stall_o=0, scoreboard clear, file 0; held instruction never appears on enable_o.

Source files
------------

// File: rtl/pa_pkg.sv
// Shared constants and the instruction record used by the operand fetch stage.
package pa_pkg;

    localparam int PA_DATA_W     = 16;
    localparam int PA_REG_ADDR_W = 5;
    localparam int PA_REG_COUNT  = 32;

    localparam logic [1:0] FT_NOP   = 2'd0;
    localparam logic [1:0] FT_ARITH = 2'd1;
    localparam logic [1:0] FT_LDST  = 2'd2;
    localparam logic [1:0] FT_FLOW  = 2'd3;

    localparam logic FMT_RR = 1'b0;
    localparam logic FMT_RI = 1'b1;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [1:0]  ftype;
        logic        fmt;
        logic [4:0]  prim;
        logic [15:0] sec;
        logic        p_read;
        logic        p_write;
        logic        s_read;
    } fetch_instr_t;

    // The secondary field names a register only for reads in register-register form.
    function automatic logic sec_is_reg(input logic s_read, input logic fmt);
        return s_read && (fmt == FMT_RR);
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-side, writeback-side and execute-side signals of the operand fetch stage.
// Handshake: the stage accepts enable_i only while stall_o is low; while stall_o is
// high decode must hold its instruction and enable_i is ignored. enable_o is a
// one-cycle valid toward execute with no backpressure.
interface operand_fetch_if #(
    parameter int DATA_W     = pa_pkg::PA_DATA_W,
    parameter int REG_ADDR_W = pa_pkg::PA_REG_ADDR_W
);
    logic                  enable_i;
    logic [6:0]            opcode_i;
    logic [1:0]            functionType_i;
    logic                  format_i;
    logic [4:0]            primOperand_i;
    logic [15:0]           secOperand_i;
    logic                  pRead_i;
    logic                  pWrite_i;
    logic                  sRead_i;
    logic                  wbEnable_i;
    logic [REG_ADDR_W-1:0] wbReg_i;
    logic [DATA_W-1:0]     wbData_i;

    logic                  stall_o;
    logic                  enable_o;
    logic [6:0]            opcode_o;
    logic [1:0]            functionType_o;
    logic [REG_ADDR_W-1:0] destReg_o;
    logic                  pWrite_o;
    logic [DATA_W-1:0]     primVal_o;
    logic [DATA_W-1:0]     secVal_o;

    modport master (
        output enable_i, opcode_i, functionType_i, format_i, primOperand_i, secOperand_i,
               pRead_i, pWrite_i, sRead_i, wbEnable_i, wbReg_i, wbData_i,
        input  stall_o, enable_o, opcode_o, functionType_o, destReg_o, pWrite_o,
               primVal_o, secVal_o
    );

    modport slave (
        input  enable_i, opcode_i, functionType_i, format_i, primOperand_i, secOperand_i,
               pRead_i, pWrite_i, sRead_i, wbEnable_i, wbReg_i, wbData_i,
        output stall_o, enable_o, opcode_o, functionType_o, destReg_o, pWrite_o,
               primVal_o, secVal_o
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// Architectural register file: two asynchronous read ports, one synchronous write port.
module reg_file_2r1w #(
    parameter int DATA_W    = 16,
    parameter int REG_COUNT = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b
);
    logic [DATA_W-1:0] r_mem [REG_COUNT];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < REG_COUNT; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: register read, pending-write scoreboard, one-entry hold
// register for hazards, and same-cycle writeback forwarding.
module operand_fetch
    import pa_pkg::*;
#(
    parameter int DATA_W     = PA_DATA_W,
    parameter int REG_COUNT  = PA_REG_COUNT,
    parameter int REG_ADDR_W = PA_REG_ADDR_W
) (
    input logic clock_i,
    input logic reset_i,
    operand_fetch_if.slave bus
);
    fetch_instr_t          r_hold;
    logic                  r_hold_valid;
    logic [REG_COUNT-1:0]  r_pending;

    fetch_instr_t          w_cand;
    logic                  w_cand_valid;
    logic                  w_is_nop, w_p_read, w_p_write, w_s_reg;
    logic [REG_ADDR_W-1:0] w_prim_idx, w_sec_idx;
    logic [REG_COUNT-1:0]  w_wb_mask, w_set_mask, w_busy;
    logic                  w_hazard, w_issue;
    logic [DATA_W-1:0]     w_rd_a, w_rd_b, w_prim_val, w_sec_val;

    reg_file_2r1w #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT), .ADDR_W(REG_ADDR_W)) u_rf (
        .i_clk     (clock_i),
        .i_rst     (reset_i),
        .i_we      (bus.wbEnable_i),
        .i_waddr   (bus.wbReg_i),
        .i_wdata   (bus.wbData_i),
        .i_raddr_a (w_prim_idx),
        .o_rdata_a (w_rd_a),
        .i_raddr_b (w_sec_idx),
        .o_rdata_b (w_rd_b)
    );

    // Held instruction has priority; a new one from decode is only seen when none is held.
    always_comb begin
        w_cand       = r_hold;
        w_cand_valid = r_hold_valid;
        if (!r_hold_valid) begin
            w_cand       = '{bus.opcode_i, bus.functionType_i, bus.format_i, bus.primOperand_i,
                             bus.secOperand_i, bus.pRead_i, bus.pWrite_i, bus.sRead_i};
            w_cand_valid = bus.enable_i;
        end
    end

    assign w_is_nop   = (w_cand.ftype == FT_NOP);
    assign w_p_read   = w_cand.p_read && !w_is_nop;
    assign w_p_write  = w_cand.p_write && !w_is_nop;
    assign w_s_reg    = sec_is_reg(w_cand.s_read, w_cand.fmt) && !w_is_nop;
    assign w_prim_idx = REG_ADDR_W'(w_cand.prim);
    assign w_sec_idx  = w_cand.sec[REG_ADDR_W-1:0];

    // A register written back this cycle is treated as ready and forwarded.
    always_comb begin
        w_wb_mask = '0;
        if (bus.wbEnable_i) w_wb_mask[bus.wbReg_i] = 1'b1;
    end
    assign w_busy = r_pending & ~w_wb_mask;

    assign w_hazard = ((w_p_read || w_p_write) && w_busy[w_prim_idx]) ||
                      (w_s_reg && w_busy[w_sec_idx]);
    assign w_issue  = w_cand_valid && !w_hazard;

    assign w_prim_val = (bus.wbEnable_i && bus.wbReg_i == w_prim_idx) ? bus.wbData_i : w_rd_a;
    assign w_sec_val  = (bus.wbEnable_i && bus.wbReg_i == w_sec_idx)  ? bus.wbData_i : w_rd_b;

    always_comb begin
        w_set_mask = '0;
        if (w_issue && w_p_write) w_set_mask[w_prim_idx] = 1'b1;
    end

    assign bus.stall_o = r_hold_valid;

    // Set wins over clear when an issuing writer and a writeback hit the same register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) r_pending <= '0;
        else         r_pending <= (r_pending & ~w_wb_mask) | w_set_mask;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_hold             <= '0;
            r_hold_valid       <= 1'b0;
            bus.enable_o       <= 1'b0;
            bus.opcode_o       <= '0;
            bus.functionType_o <= '0;
            bus.destReg_o      <= '0;
            bus.pWrite_o       <= 1'b0;
            bus.primVal_o      <= '0;
            bus.secVal_o       <= '0;
        end else if (w_issue) begin
            r_hold_valid       <= 1'b0;
            bus.enable_o       <= 1'b1;
            bus.opcode_o       <= w_cand.opcode;
            bus.functionType_o <= w_cand.ftype;
            bus.destReg_o      <= w_prim_idx;
            bus.pWrite_o       <= w_cand.p_write;
            bus.primVal_o      <= w_p_read ? w_prim_val : '0;
            bus.secVal_o       <= w_s_reg ? w_sec_val : DATA_W'(w_cand.sec);
        end else begin
            bus.enable_o <= 1'b0;
            if (w_cand_valid) begin
                r_hold       <= w_cand;
                r_hold_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios then random traffic against a reference model.
module tb_operand_fetch;
    import pa_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int NR    = 32;
    localparam int OUT_W = 1 + 7 + 2 + 5 + 1 + 16 + 16;

    // clock / reset
    logic clock_i = 1'b0;
    logic reset_i = 1'b1;
    always #5 clock_i = ~clock_i;

    operand_fetch_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

    operand_fetch #(.DATA_W(DW), .REG_COUNT(NR), .REG_ADDR_W(AW)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    // reference model state
    logic [DW-1:0]    m_file [NR];
    logic             m_pend [NR];
    fetch_instr_t     m_hold [$];
    logic [OUT_W-1:0] m_out;
    logic [OUT_W-1:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic fetch_instr_t mk(input logic [6:0] opc, input logic [1:0] ft, input logic fmt,
                                        input logic [4:0] prim, input logic [15:0] sec,
                                        input logic pr, input logic pw, input logic sr);
        fetch_instr_t t;
        t = '{opc, ft, fmt, prim, sec, pr, pw, sr};
        return t;
    endfunction

    function automatic logic busy(input logic [4:0] r, input logic wbe, input logic [4:0] wbr);
        return m_pend[r] && !(wbe && wbr == r);
    endfunction

    function automatic logic [DW-1:0] rd(input logic [4:0] r, input logic wbe, input logic [4:0] wbr,
                                         input logic [DW-1:0] wbd);
        return (wbe && wbr == r) ? wbd : m_file[r];
    endfunction

    function automatic logic [OUT_W-1:0] observed();
        return {bus.enable_o, bus.opcode_o, bus.functionType_o, bus.destReg_o, bus.pWrite_o,
                bus.primVal_o, bus.secVal_o};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_file[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_hold.delete();
        m_out = '0;
    endtask

    // driver: one cycle of decode + writeback stimulus, checked against the model
    task automatic step(input logic en, input fetch_instr_t ins, input logic wbe,
                        input logic [4:0] wbr, input logic [DW-1:0] wbd);
        fetch_instr_t c;
        logic cv, nop, pr, pw, sr, haz;
        logic [4:0] si;
        logic [DW-1:0] pv, sv;
        @(negedge clock_i);
        bus.enable_i       = en;
        bus.opcode_i       = ins.opcode;
        bus.functionType_i = ins.ftype;
        bus.format_i       = ins.fmt;
        bus.primOperand_i  = ins.prim;
        bus.secOperand_i   = ins.sec;
        bus.pRead_i        = ins.p_read;
        bus.pWrite_i       = ins.p_write;
        bus.sRead_i        = ins.s_read;
        bus.wbEnable_i     = wbe;
        bus.wbReg_i        = wbr;
        bus.wbData_i       = wbd;
        #1;
        check("stall_o", bus.stall_o, m_hold.size() != 0);

        cv  = (m_hold.size() != 0) || en;
        c   = (m_hold.size() != 0) ? m_hold[0] : ins;
        nop = (c.ftype == FT_NOP);
        pr  = c.p_read && !nop;
        pw  = c.p_write && !nop;
        sr  = c.s_read && (c.fmt == FMT_RR) && !nop;
        si  = c.sec[4:0];
        haz = ((pr || pw) && busy(c.prim, wbe, wbr)) || (sr && busy(si, wbe, wbr));
        if (cv && !haz) begin
            pv    = pr ? rd(c.prim, wbe, wbr, wbd) : '0;
            sv    = sr ? rd(si, wbe, wbr, wbd) : c.sec;
            m_out = {1'b1, c.opcode, c.ftype, c.prim, c.p_write, pv, sv};
            m_hold.delete();
        end else begin
            m_out[OUT_W-1] = 1'b0;
            if (cv && m_hold.size() == 0) m_hold.push_back(c);
        end
        if (wbe) begin
            m_file[wbr] = wbd;
            m_pend[wbr] = 1'b0;
        end
        if (cv && !haz && pw) m_pend[c.prim] = 1'b1;
        exp_q.push_back(m_out);

        @(posedge clock_i);
        #1;
        check("outputs", observed(), exp_q.pop_front());
    endtask

    task automatic idle(input logic wbe, input logic [4:0] wbr, input logic [DW-1:0] wbd);
        step(1'b0, '0, wbe, wbr, wbd);
    endtask

    task automatic do_reset();
        @(negedge clock_i);
        reset_i = 1'b1;
        bus.enable_i   = 1'b0;
        bus.wbEnable_i = 1'b0;
        #1;
        model_clear();
        check("reset_outputs", observed(), '0);
        check("reset_stall", bus.stall_o, 1'b0);
        @(negedge clock_i);
        reset_i = 1'b0;
    endtask

    fetch_instr_t cur;
    logic [4:0]   pend_list [$];

    initial begin
        bus.enable_i = 1'b0; bus.opcode_i = '0; bus.functionType_i = '0; bus.format_i = 1'b0;
        bus.primOperand_i = '0; bus.secOperand_i = '0; bus.pRead_i = 1'b0; bus.pWrite_i = 1'b0;
        bus.sRead_i = 1'b0; bus.wbEnable_i = 1'b0; bus.wbReg_i = '0; bus.wbData_i = '0;
        model_clear();
        repeat (2) @(posedge clock_i);
        do_reset();

        // reg-reg read of a written register
        idle(1'b1, 5'd3, 16'h1234);
        step(1'b1, mk(7'h10, FT_ARITH, FMT_RR, 5'd3, 16'h0003, 1, 0, 1), 0, 0, 0);
        check("rr_enable", bus.enable_o, 1'b1);
        check("rr_prim", bus.primVal_o, 16'h1234);
        check("rr_sec", bus.secVal_o, 16'h1234);
        check("rr_dest", bus.destReg_o, 5'd3);

        // immediate form, then RAW stall released by writeback
        step(1'b1, mk(7'h11, FT_ARITH, FMT_RI, 5'd2, 16'hBEEF, 1, 1, 1), 0, 0, 0);
        check("ri_sec", bus.secVal_o, 16'hBEEF);
        step(1'b1, mk(7'h12, FT_ARITH, FMT_RI, 5'd2, 16'h0001, 1, 0, 1), 0, 0, 0);
        check("raw_stall", bus.stall_o, 1'b1);
        check("raw_no_issue", bus.enable_o, 1'b0);
        idle(1'b1, 5'd2, 16'h0005);
        check("raw_release", bus.enable_o, 1'b1);
        check("raw_fwd", bus.primVal_o, 16'h0005);

        // hazard resolved by same-cycle writeback: no stall cycle
        step(1'b1, mk(7'h13, FT_LDST, FMT_RI, 5'd4, 16'h0000, 0, 1, 0), 0, 0, 0);
        step(1'b1, mk(7'h14, FT_ARITH, FMT_RI, 5'd4, 16'h0002, 1, 0, 0), 1, 5'd4, 16'h00AA);
        check("fwd_enable", bus.enable_o, 1'b1);
        check("fwd_prim", bus.primVal_o, 16'h00AA);
        check("fwd_stall", bus.stall_o, 1'b0);

        // issue-set beats same-cycle writeback clear
        step(1'b1, mk(7'h15, FT_LDST, FMT_RI, 5'd7, 16'h0000, 0, 1, 0), 0, 0, 0);
        step(1'b1, mk(7'h16, FT_LDST, FMT_RI, 5'd7, 16'h0000, 0, 1, 0), 1, 5'd7, 16'h0777);
        check("setwins_issue", bus.enable_o, 1'b1);
        step(1'b1, mk(7'h17, FT_ARITH, FMT_RI, 5'd7, 16'h0000, 1, 0, 0), 0, 0, 0);
        check("setwins_stall", bus.stall_o, 1'b1);
        idle(1'b1, 5'd7, 16'h0778);
        check("setwins_val", bus.primVal_o, 16'h0778);

        // WAW on r1
        step(1'b1, mk(7'h20, FT_LDST, FMT_RI, 5'd1, 16'h0000, 0, 1, 0), 0, 0, 0);
        step(1'b1, mk(7'h21, FT_LDST, FMT_RI, 5'd1, 16'h0004, 0, 1, 0), 0, 0, 0);
        idle(0, 0, 0);
        check("waw_hold", bus.stall_o, 1'b1);
        idle(1'b1, 5'd1, 16'h0101);
        check("waw_issue", bus.enable_o, 1'b1);
        step(1'b1, mk(7'h22, FT_ARITH, FMT_RI, 5'd1, 16'h0000, 1, 0, 0), 0, 0, 0);
        check("waw_repend", bus.stall_o, 1'b1);
        idle(1'b1, 5'd1, 16'h0202);

        // nop never stalls, even on a pending register
        step(1'b1, mk(7'h30, FT_LDST, FMT_RI, 5'd6, 16'h0000, 0, 1, 0), 0, 0, 0);
        step(1'b1, mk(7'h31, FT_NOP, FMT_RR, 5'd6, 16'h0006, 1, 1, 1), 0, 0, 0);
        check("nop_issue", bus.enable_o, 1'b1);
        check("nop_prim", bus.primVal_o, 16'h0000);

        // reset during a stall discards the held instruction
        step(1'b1, mk(7'h32, FT_ARITH, FMT_RI, 5'd6, 16'h0000, 1, 0, 0), 0, 0, 0);
        check("pre_reset_stall", bus.stall_o, 1'b1);
        do_reset();
        repeat (3) idle(0, 0, 0);
        step(1'b1, mk(7'h33, FT_ARITH, FMT_RR, 5'd6, 16'h0003, 1, 0, 1), 0, 0, 0);
        check("post_reset_issue", bus.enable_o, 1'b1);
        check("post_reset_file", bus.secVal_o, 16'h0000);

        // random traffic
        cur = '0;
        for (int n = 0; n < 400; n++) begin
            logic en, wbe;
            logic [4:0] wbr;
            if (!bus.stall_o) begin
                cur = mk(7'($urandom_range(0, 127)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         5'($urandom_range(0, 7)),
                         {11'($urandom_range(0, 2047)), 5'($urandom_range(0, 7))},
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            en = ($urandom_range(0, 3) != 0);
            pend_list.delete();
            for (int r = 0; r < 8; r++) if (m_pend[r]) pend_list.push_back(5'(r));
            wbe = ($urandom_range(0, 1) == 1);
            if (pend_list.size() != 0 && $urandom_range(0, 2) != 0)
                wbr = pend_list[$urandom_range(0, pend_list.size() - 1)];
            else
                wbr = 5'($urandom_range(0, 7));
            step(en, cur, wbe, wbr, 16'($urandom_range(0, 65535)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
